pipeline_hazard_ctrl: RTL and testbench

//  Sequencing controller for the 4-stage pipelined regfile/ALU datapath (IF, ID, EXE, WB).

---
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the 4-stage (IF, ID, EXE, WB) regfile/ALU pipeline.
//   It tracks the destinations of the instructions in the EXE and WB slots and checks
//   them against the sources of the instruction in ID (RAW hazards). From that it drives
//   the operand-forwarding selects and the stall and bubble controls. It also drives the
//   EXE hold that long (multi-cycle) ALU ops need.
//
//   Build option: define HAZARD_FWD_EN to enable operand forwarding.
//   When it is not defined, a RAW hazard stalls ID until the producer has retired.
//
// Ports
//   clk, rst                clock; synchronous active-low reset
//   id_valid                ID holds a real instruction
//   id_rs1/id_rs2           ID source addresses; id_use_rs2=0 means rs2 is not read
//   id_wen/id_waddr         ID destination write enable / address
//   id_multi                ID instruction is a multi-cycle EXE op
//   ex_flush                branch taken in EXE, squash the ID instruction
//   stall                   hold PC and IF/ID
//   bubble                  load NOP into ID/EXE
//   exe_hold                hold ID/EXE, load NOP into EXE/WB
//   fwd_a/fwd_b             operand select: 00 regfile, 01 EXE result, 10 EXE/WB result
//   wb_commit               WB slot writes the regfile this cycle
//   mbusy                   a multi-cycle op is occupying EXE
module pipeline_hazard_ctrl #(
  parameter int AW       = 4,
  parameter int MULT_LAT = 4,
  parameter bit R0_ZERO  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use_rs2,
  input  logic          id_wen,
  input  logic [AW-1:0] id_waddr,
  input  logic          id_multi,
  input  logic          ex_flush,
  output logic          stall,
  output logic          bubble,
  output logic          exe_hold,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          wb_commit,
  output logic          mbusy
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_MBUSY = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 1);

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic          exe_v, exe_wen, wb_v, wb_wen;
  logic [AW-1:0] exe_waddr, wb_waddr;

  function automatic logic hit(input logic v, input logic wen,
                               input logic [AW-1:0] wa, input logic [AW-1:0] r);
    return v & wen & (wa == r) & ~(R0_ZERO & (r == '0));
  endfunction

  logic busy, run, flush;
  logic ea, wa, eb, wbb;
  logic raw_stall, stall_c, bubble_c, load;
  logic [1:0] fa, fb;

  assign busy  = (state == S_MBUSY);
  assign run   = ~busy;
  // A flush is only honoured in RUN. In MBUSY the ID instruction is held anyway.
  assign flush = run & ex_flush;

  assign ea  = hit(exe_v, exe_wen, exe_waddr, id_rs1);
  assign wa  = hit(wb_v,  wb_wen,  wb_waddr,  id_rs1);
  assign eb  = id_use_rs2 & hit(exe_v, exe_wen, exe_waddr, id_rs2);
  assign wbb = id_use_rs2 & hit(wb_v,  wb_wen,  wb_waddr,  id_rs2);

`ifdef HAZARD_FWD_EN
  // The EXE result is ready in the same cycle, so RAW never stalls.
  // The youngest producer (EXE) takes priority over WB.
  assign raw_stall = 1'b0;
  assign fa = ea ? 2'b01 : (wa  ? 2'b10 : 2'b00);
  assign fb = eb ? 2'b01 : (wbb ? 2'b10 : 2'b00);
`else
  logic raw;
  assign raw       = id_valid & (ea | wa | eb | wbb);
  assign raw_stall = run & raw;
  assign fa        = 2'b00;
  assign fb        = 2'b00;
`endif

  // A squashed instruction never stalls, so flush overrides a pending RAW stall.
  assign stall_c  = busy | (raw_stall & ~flush);
  assign bubble_c = run & (flush | raw_stall);
  assign load     = run & id_valid & ~bubble_c & ~stall_c;

  // All outputs are forced low while reset is held.
  assign stall     = rst & stall_c;
  assign bubble    = rst & bubble_c;
  assign exe_hold  = rst & busy;
  assign mbusy     = rst & busy;
  assign wb_commit = rst & wb_v & wb_wen;
  assign fwd_a     = rst ? fa : 2'b00;
  assign fwd_b     = rst ? fb : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      cnt       <= '0;
      exe_v     <= 1'b0;
      exe_wen   <= 1'b0;
      exe_waddr <= '0;
      wb_v      <= 1'b0;
      wb_wen    <= 1'b0;
      wb_waddr  <= '0;
    end else if (busy) begin
      // EXE is frozen on the multi-cycle op and WB drains to NOP.
      wb_v <= 1'b0;
      cnt  <= cnt - 4'd1;
      if (cnt == 4'd1) state <= S_RUN;
    end else begin
      wb_v      <= exe_v;
      wb_wen    <= exe_wen;
      wb_waddr  <= exe_waddr;
      exe_v     <= load;
      exe_wen   <= id_wen;
      exe_waddr <= id_waddr;
      // The entry cycle counts as the first EXE cycle, so MULT_LAT-1 hold cycles follow.
      if (load & id_multi) begin
        cnt   <= CNT_INIT;
        state <= S_MBUSY;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int AW       = 4;
  localparam int MULT_LAT = 4;
  localparam bit R0_ZERO  = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid, id_use_rs2, id_wen, id_multi, ex_flush;
  logic [AW-1:0] id_rs1, id_rs2, id_waddr;
  logic          stall, bubble, exe_hold, wb_commit, mbusy;
  logic [1:0]    fwd_a, fwd_b;

  int tests = 0;
  int fails = 0;
  string cur = "init";

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.AW(AW), .MULT_LAT(MULT_LAT), .R0_ZERO(R0_ZERO)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_wen(id_wen), .id_waddr(id_waddr), .id_multi(id_multi),
    .ex_flush(ex_flush), .stall(stall), .bubble(bubble), .exe_hold(exe_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_commit(wb_commit), .mbusy(mbusy)
  );

  // Reference model: contents of the two in-flight slots, plus how many hold cycles the
  // multi-cycle op still owes.
  bit m_ex_v, m_ex_wen, m_wb_v, m_wb_wen;
  int m_ex_wa, m_wb_wa;
  int m_hold_left;
  bit e_stall, e_bubble, e_hold, e_mbusy, e_commit;
  int e_fa, e_fb;

  function automatic bit writes(bit v, bit wen, int wa, int r);
    return v && wen && (wa == r) && !(R0_ZERO && r == 0);
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int rs1, int rs2, bit u2, bit wen, int wa, bit multi, bit fl);
    id_valid = v; id_rs1 = rs1[AW-1:0]; id_rs2 = rs2[AW-1:0]; id_use_rs2 = u2;
    id_wen = wen; id_waddr = wa[AW-1:0]; id_multi = multi; ex_flush = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compute the expected outputs from the model, then compare them with the DUT.
  task automatic look(string name);
    bit busy, dep, squash, raw_wait;
    int r1, r2;
    cur = name;
    #1;
    r1 = int'(id_rs1); r2 = int'(id_rs2);
    e_stall = 0; e_bubble = 0; e_hold = 0; e_mbusy = 0; e_commit = 0; e_fa = 0; e_fb = 0;
    if (rst) begin
      busy   = (m_hold_left > 0);
      dep    = writes(m_ex_v, m_ex_wen, m_ex_wa, r1) || writes(m_wb_v, m_wb_wen, m_wb_wa, r1) ||
               (id_use_rs2 && (writes(m_ex_v, m_ex_wen, m_ex_wa, r2) ||
                               writes(m_wb_v, m_wb_wen, m_wb_wa, r2)));
      squash = !busy && ex_flush;
`ifdef HAZARD_FWD_EN
      raw_wait = 0;
      if (writes(m_ex_v, m_ex_wen, m_ex_wa, r1)) e_fa = 1;
      else if (writes(m_wb_v, m_wb_wen, m_wb_wa, r1)) e_fa = 2;
      if (id_use_rs2) begin
        if (writes(m_ex_v, m_ex_wen, m_ex_wa, r2)) e_fb = 1;
        else if (writes(m_wb_v, m_wb_wen, m_wb_wa, r2)) e_fb = 2;
      end
`else
      raw_wait = !busy && id_valid && dep;
`endif
      e_stall  = busy || (raw_wait && !squash);
      e_bubble = !busy && (squash || raw_wait);
      e_hold   = busy;
      e_mbusy  = busy;
      e_commit = m_wb_v && m_wb_wen;
    end
    chk("stall", 8'(stall), 8'(e_stall));
    chk("bubble", 8'(bubble), 8'(e_bubble));
    chk("exe_hold", 8'(exe_hold), 8'(e_hold));
    chk("mbusy", 8'(mbusy), 8'(e_mbusy));
    chk("wb_commit", 8'(wb_commit), 8'(e_commit));
    chk("fwd_a", 8'(fwd_a), 8'(e_fa));
    chk("fwd_b", 8'(fwd_b), 8'(e_fb));
  endtask

  // Clock edge: update the model from the values that were present before the edge.
  task automatic advance();
    bit take;
    @(posedge clk);
    if (!rst) begin
      m_ex_v = 0; m_ex_wen = 0; m_ex_wa = 0; m_wb_v = 0; m_wb_wen = 0; m_wb_wa = 0;
      m_hold_left = 0;
    end else if (m_hold_left > 0) begin
      m_wb_v = 0;
      m_hold_left--;
    end else begin
      m_wb_v = m_ex_v; m_wb_wen = m_ex_wen; m_wb_wa = m_ex_wa;
      take = id_valid && !e_stall && !e_bubble;
      m_ex_v = take; m_ex_wen = id_wen; m_ex_wa = int'(id_waddr);
      if (take && id_multi) m_hold_left = MULT_LAT - 1;
    end
    @(negedge clk);
  endtask

  task automatic cyc(string name);
    look(name);
    advance();
  endtask

  initial begin
    m_ex_v = 0; m_ex_wen = 0; m_ex_wa = 0; m_wb_v = 0; m_wb_wen = 0; m_wb_wa = 0;
    m_hold_left = 0;
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    @(negedge clk);

    // Reset held with busy inputs: all outputs 0.
    look("rst0"); chk("k_stall", 8'(stall), 8'd0); chk("k_bubble", 8'(bubble), 8'd0); advance();
    look("rst1"); chk("k_fwd_a", 8'(fwd_a), 8'd0); advance();
    rst = 1'b1; nop();
    look("rel"); chk("k_mbusy", 8'(mbusy), 8'd0); chk("k_commit", 8'(wb_commit), 8'd0); advance();

`ifdef HAZARD_FWD_EN
    // T1: back-to-back dependency, forwarded from EXE.
    drive(1, 2, 3, 1, 1, 1, 0, 0); cyc("t1_add");
    drive(1, 1, 3, 1, 1, 2, 0, 0); look("t1_sub");
    chk("k_fwd_a", 8'(fwd_a), 8'd1); chk("k_fwd_b", 8'(fwd_b), 8'd0); chk("k_stall", 8'(stall), 8'd0);
    advance();
    nop(); cyc("t1_d0"); cyc("t1_d1");
    // T2: producer two ahead forwards from WB; producer in both slots -> EXE wins.
    drive(1, 2, 3, 1, 1, 1, 0, 0); cyc("t2_add");
    nop(); cyc("t2_nop");
    drive(1, 1, 3, 0, 1, 2, 0, 0); look("t2_sub"); chk("k_fwd_a", 8'(fwd_a), 8'd2); advance();
    drive(1, 2, 3, 1, 1, 1, 0, 0); cyc("t2_a1");
    drive(1, 2, 3, 1, 1, 1, 0, 0); cyc("t2_a2");
    drive(1, 1, 1, 1, 1, 2, 0, 0); look("t2_both");
    chk("k_fwd_a", 8'(fwd_a), 8'd1); chk("k_fwd_b", 8'(fwd_b), 8'd1); advance();
`else
    // T3: back-to-back dependency, no forwarding -> exactly 2 stall cycles.
    drive(1, 2, 3, 1, 1, 1, 0, 0); look("t3_add"); chk("k_stall", 8'(stall), 8'd0); advance();
    drive(1, 1, 3, 1, 1, 2, 0, 0);
    look("t3_s0"); chk("k_stall", 8'(stall), 8'd1); chk("k_bubble", 8'(bubble), 8'd1); advance();
    look("t3_s1"); chk("k_stall", 8'(stall), 8'd1); chk("k_bubble", 8'(bubble), 8'd1); advance();
    look("t3_s2"); chk("k_stall", 8'(stall), 8'd0); chk("k_fwd_a", 8'(fwd_a), 8'd0); advance();
`endif
    nop(); cyc("d0"); cyc("d1");

    // T4: multi-cycle producer; dependent ADD waits through MBUSY (flush ignored there).
    drive(1, 1, 2, 1, 1, 4, 1, 0); look("t4_mul"); chk("k_stall", 8'(stall), 8'd0); advance();
    drive(1, 4, 4, 1, 1, 5, 0, 1);
    for (int i = 0; i < MULT_LAT - 1; i++) begin
      look($sformatf("t4_busy%0d", i));
      chk("k_stall", 8'(stall), 8'd1); chk("k_hold", 8'(exe_hold), 8'd1);
      chk("k_mbusy", 8'(mbusy), 8'd1); chk("k_bubble", 8'(bubble), 8'd0);
      advance();
    end
    drive(1, 4, 4, 1, 1, 5, 0, 0);
`ifdef HAZARD_FWD_EN
    look("t4_run"); chk("k_mbusy", 8'(mbusy), 8'd0); chk("k_stall", 8'(stall), 8'd0);
    chk("k_fwd_a", 8'(fwd_a), 8'd1); advance();
`else
    look("t4_run"); chk("k_mbusy", 8'(mbusy), 8'd0); chk("k_stall", 8'(stall), 8'd1); advance();
    look("t4_wb"); chk("k_stall", 8'(stall), 8'd1); chk("k_commit", 8'(wb_commit), 8'd1); advance();
    look("t4_go"); chk("k_stall", 8'(stall), 8'd0); advance();
`endif
    nop(); cyc("d2"); cyc("d3");

    // T5: r0 never hazards; flush with a pending RAW squashes without stalling.
    drive(1, 1, 2, 1, 1, 0, 0, 0); cyc("t5_add_r0");
    drive(1, 0, 0, 1, 1, 1, 0, 0); look("t5_sub");
    chk("k_stall", 8'(stall), 8'd0); chk("k_fwd_a", 8'(fwd_a), 8'd0); chk("k_bubble", 8'(bubble), 8'd0);
    advance();
    drive(1, 1, 3, 1, 1, 6, 0, 1); look("t5_flush");
    chk("k_bubble", 8'(bubble), 8'd1); chk("k_stall", 8'(stall), 8'd0); advance();
    nop(); look("t5_wb"); chk("k_commit", 8'(wb_commit), 8'd1); advance();
    cyc("d4");

    // T6: reset during the second MBUSY cycle discards the op.
    drive(1, 0, 0, 0, 1, 7, 1, 0); cyc("t6_mul");
    nop(); look("t6_b1"); chk("k_mbusy", 8'(mbusy), 8'd1); advance();
    rst = 1'b0; look("t6_rst");
    chk("k_stall", 8'(stall), 8'd0); chk("k_hold", 8'(exe_hold), 8'd0); chk("k_mbusy", 8'(mbusy), 8'd0);
    advance();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      look($sformatf("t6_after%0d", i));
      chk("k_commit", 8'(wb_commit), 8'd0); chk("k_mbusy", 8'(mbusy), 8'd0);
      advance();
    end

    // Randomized traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      cyc($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
